// File: rtl/stm32_bus_pkg.sv
// Shared constants and helpers for the STM32 parallel bus initiator.
package stm32_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WRITE,
    ST_READ,
    ST_GAP
  } state_t;

  localparam logic [2:0] CMD_BUS_TEST    = 3'd0;
  localparam logic [2:0] CMD_GET_PARAMS  = 3'd1;
  localparam logic [2:0] CMD_SEND_PARAMS = 3'd2;
  localparam logic [2:0] CMD_TX_IQ       = 3'd3;
  localparam logic [2:0] CMD_RX_IQ       = 3'd4;
  localparam logic [2:0] CMD_AUDIO_ON    = 3'd5;
  localparam logic [2:0] CMD_AUDIO_OFF   = 3'd6;
  localparam logic [2:0] CMD_FLASH_READ  = 3'd7;

  // Cycle offsets from T0 at which the first read byte is sampled, and flash stride.
  localparam int unsigned READ_START_OFFSET  = 2;
  localparam int unsigned FLASH_START_OFFSET = 3;
  localparam int unsigned FLASH_STRIDE       = 2;

  // Number of payload bytes the initiator drives after the command byte.
  function automatic logic [2:0] wr_bytes(input logic [2:0] cmd);
    case (cmd)
      CMD_BUS_TEST, CMD_FLASH_READ: wr_bytes = 3'd1;
      CMD_GET_PARAMS, CMD_TX_IQ:    wr_bytes = 3'd4;
      CMD_SEND_PARAMS, CMD_RX_IQ,
      CMD_AUDIO_ON, CMD_AUDIO_OFF:  wr_bytes = 3'd0;
      default:                      wr_bytes = 3'd0;
    endcase
  endfunction

  // Fixed read byte count; flash reads take their length from the request instead.
  function automatic logic [3:0] rd_bytes(input logic [2:0] cmd);
    case (cmd)
      CMD_BUS_TEST:    rd_bytes = 4'd1;
      CMD_SEND_PARAMS: rd_bytes = 4'd5;
      CMD_RX_IQ:       rd_bytes = 4'd8;
      default:         rd_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/stm32_bus_initiator.sv
// Initiator side of the 8-bit STM32 parallel bus: one command transaction per request.
module stm32_bus_initiator
  import stm32_bus_pkg::*;
#(
  parameter int unsigned IDLE_GAP    = 2,
  parameter int unsigned FLASH_LEN_W = 16
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_code,
  input  logic [31:0]            wr_data,
  input  logic [FLASH_LEN_W-1:0] flash_len,
  output logic                   DATA_SYNC,
  inout  wire  [7:0]             DATA_BUS,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [FLASH_LEN_W-1:0] rd_index,
  output logic                   done,
  output logic                   busy
);

  localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  state_t                 state_q, state_d;
  logic [2:0]             cmd_q, cmd_d;
  logic [31:0]            wr_q, wr_d;
  logic [2:0]             n_wr_q, n_wr_d;
  logic [2:0]             byte_cnt_q, byte_cnt_d;
  logic [FLASH_LEN_W-1:0] rd_left_q, rd_left_d;
  logic [1:0]             skip_q, skip_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   sync_q, sync_d;
  logic                   oe_q, oe_d;
  logic [7:0]             dout_q, dout_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [FLASH_LEN_W-1:0] rd_index_q, rd_index_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   busy_q;
  logic                   go_read, go_gap;
  int unsigned            rd_start;

  // Master drive of the shared bus only while sending command or write bytes.
  assign DATA_BUS  = oe_q ? dout_q : 8'bz;
  assign DATA_SYNC = sync_q;
  assign cmd_ready = ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_index  = rd_index_q;
  assign done      = done_q;
  assign busy      = busy_q;

  // Next state plus the registered outputs for the upcoming cycle.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wr_d       = wr_q;
    n_wr_d     = n_wr_q;
    byte_cnt_d = byte_cnt_q;
    rd_left_d  = rd_left_q;
    skip_d     = skip_q;
    gap_d      = gap_q;
    sync_d     = 1'b0;
    oe_d       = 1'b0;
    dout_d     = dout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    ready_d    = 1'b0;
    rd_index_d = rd_index_q + FLASH_LEN_W'(rd_valid_q);
    go_read    = 1'b0;
    go_gap     = 1'b0;
    rd_start   = (cmd_q == CMD_FLASH_READ) ? FLASH_START_OFFSET : READ_START_OFFSET;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          state_d    = ST_SYNC;
          cmd_d      = cmd_code;
          wr_d       = wr_data;
          n_wr_d     = wr_bytes(cmd_code);
          rd_left_d  = (cmd_code == CMD_FLASH_READ) ? flash_len
                                                    : FLASH_LEN_W'(rd_bytes(cmd_code));
          byte_cnt_d = 3'd0;
          sync_d     = 1'b1;
          oe_d       = 1'b1;
          dout_d     = {5'b0, cmd_code};
          ready_d    = 1'b0;
          rd_index_d = '0;
        end
      end
      ST_SYNC, ST_WRITE: begin
        if (byte_cnt_q < n_wr_q) begin
          state_d    = ST_WRITE;
          oe_d       = 1'b1;
          dout_d     = wr_q[31:24];
          wr_d       = {wr_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 3'd1;
        end else if (rd_left_q != '0) begin
          go_read = 1'b1;
        end else begin
          go_gap = 1'b1;
        end
      end
      ST_READ: begin
        if (skip_q != 2'd0) begin
          skip_d = skip_q - 2'd1;
        end else begin
          rd_valid_d = 1'b1;
          rd_data_d  = DATA_BUS;
          rd_left_d  = rd_left_q - FLASH_LEN_W'(1);
          skip_d     = (cmd_q == CMD_FLASH_READ) ? 2'(FLASH_STRIDE - 1) : 2'd0;
          if (rd_left_q == FLASH_LEN_W'(1)) go_gap = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(IDLE_GAP - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d  = gap_q + GAP_W'(1);
          done_d = (32'(gap_q) + 32'd1 == IDLE_GAP - 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Wait cycles before the first sample depend on where the read phase begins.
    if (go_read) begin
      state_d = ST_READ;
      skip_d  = 2'(rd_start - 32'(n_wr_q) - 32'd1);
    end
    if (go_gap) begin
      state_d = ST_GAP;
      gap_d   = '0;
      done_d  = (IDLE_GAP == 1);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 3'd0;
      wr_q       <= 32'd0;
      n_wr_q     <= 3'd0;
      byte_cnt_q <= 3'd0;
      rd_left_q  <= '0;
      skip_q     <= 2'd0;
      gap_q      <= '0;
      sync_q     <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_index_q <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wr_q       <= wr_d;
      n_wr_q     <= n_wr_d;
      byte_cnt_q <= byte_cnt_d;
      rd_left_q  <= rd_left_d;
      skip_q     <= skip_d;
      gap_q      <= gap_d;
      sync_q     <= sync_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_index_q <= rd_index_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= ~ready_d;
    end
  end

endmodule

// File: doc/stm32_bus_initiator.md
Name: stm32_bus_initiator

Overview:
- Initiator end of the 8-bit STM32 parallel bus (DATA_SYNC strobe plus bidirectional DATA_BUS).
- Executes one command transaction per request, with exact byte timing matching the FPGA-side responder.
- Used for the on-chip loopback self-test, and as the bus master when an FPGA soft core replaces the STM32.
- Accepts a command plus write payload; returns read bytes as a strobed stream.

Parameters:
IDLE_GAP, 2, minimum cycles with DATA_SYNC=0 and bus released between transactions (≥1)
FLASH_LEN_W, 16, width of flash read length counter

Ports:
clk_in  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  request strobe
cmd_ready  output  1  high only in IDLE; transfer when cmd_valid&cmd_ready
cmd_code  input  3  0 bus test, 1 get params, 2 send params, 3 TX IQ, 4 RX IQ, 5 audio on, 6 audio off, 7 flash read
wr_data  input  32  write payload; byte0=[31:24] sent first; captured at accept
flash_len  input  FLASH_LEN_W  flash bytes to read (cmd 7); captured at accept
DATA_SYNC  output  1  command strobe
DATA_BUS  inout  8  shared bus; driven only when internal oe=1, else 8'bZ
rd_data  output  8  read byte
rd_valid  output  1  one-cycle strobe per read byte
rd_index  output  FLASH_LEN_W  byte index within transaction, from 0
done  output  1  one-cycle pulse when transaction (including gap) completes
busy  output  1  ~cmd_ready

Behaviour:
- All outputs registered. Reset values: DATA_SYNC=0, oe=0, cmd_ready=0 during reset then 1, rd_data=0, rd_valid=0, rd_index=0, done=0.
- Timeline: T0 is the cycle with DATA_SYNC=1 and DATA_BUS=cmd_code (zero-extended); the responder samples at end of T0.
- T0 is the cycle after accept; accept-to-DATA_SYNC latency is exactly 1.
- Write byte i is driven during T(1+i) with oe=1.
- Read byte i is sampled at end of T(2+i); rd_valid is high in T(3+i).
- oe=0 in every cycle not driving cmd or write bytes. No master drive after T0 for read commands.
- Per-command phases:
  - cmd0: write byte0 in T1, release; read 1 byte sampled end of T2 (echo).
  - cmd1, cmd3: 4 write bytes, T1–T4, no reads.
  - cmd2: 5 reads at T2–T6.
  - cmd4: 8 reads at T2–T9 (spectrum Q,I, then voice Q,I, hi byte first).
  - cmd5, cmd6: command only.
  - cmd7: write byte0 (flash command) in T1; flash byte j sampled end of T(3+2j), j=0..flash_len-1. Values 8'hFF are passed through unchanged (responder busy marker).
- FSM: IDLE -> SYNC (1 cycle) -> WRITE (n cycles, skipped if n=0) -> READ (skipped if no reads) -> GAP (IDLE_GAP cycles) -> IDLE.
- READ phase: one wait cycle, then samples every cycle (every 2nd for cmd7).
- done is asserted in the last GAP cycle; cmd_ready rises the next cycle.
- cmd7 with flash_len=0: after the T1 write, go straight to GAP. The responder stays in flash mode until the next DATA_SYNC; this is acceptable.
- cmd_valid while busy: ignored, no queueing.
- Reset mid-transaction: next cycle oe=0, DATA_SYNC=0, FSM=IDLE. No done or rd_valid is produced for the aborted command.
- rd_index resets to 0 at each accept and increments after each rd_valid.

Decomposition:
- Package stm32_bus_pkg: command code localparams (CMD_BUS_TEST..CMD_FLASH_READ), per-command write/read byte counts, READ_START_OFFSET=2, FLASH_STRIDE=2, FLASH_START_OFFSET=3.
- No sub-module required. The tristate assign stays in this module.

Test Plan:
- Bus test: cmd0, wr_data=32'hA5000000, echo responder model -> DATA_SYNC in T0 with bus 8'h00, bus 8'hA5 in T1, single rd_valid with rd_data=8'hA5, then done.
- Get params: cmd1, wr_data=32'h0C_09_77_77 -> bus bytes 0C,09,77,77 in T1–T4; responder model latches preamp=1, tx=1, freq=22'h097777; no rd_valid.
- RX IQ: model SPEC_I=16'h1234, SPEC_Q=16'hABCD, VOICE_I=16'h5678, VOICE_Q=16'hEF01 -> rd_data sequence AB,CD,12,34,EF,01,56,78 with rd_index 0..7.
- Flash read: cmd7, wr_data[31:24]=8'h03, flash_len=3, model busy for the first sample -> rd_data FF, then data bytes at 2-cycle stride; done follows.
- Back-to-back cmd5 then cmd6 with cmd_valid held high -> DATA_SYNC pulses separated by ≥IDLE_GAP+1 cycles; model audio_clk_en goes 1 then 0.
- Reset asserted during T4 of cmd4 -> oe=0 and DATA_SYNC=0 next cycle, no done; cmd_ready=1 after reset is released.
